// File: rtl/fadd_align_pre_n36_pkg.sv
// -----------------------------------------------------------------------------
// fadd_pkg_N36
// Shared definitions for the 36-bit floating-point adder pre-alignment stage.
// Contents:
//   - the format widths
//   - the field positions inside the packed {sign, exp, man} word
//   - the unpacked operand struct
//   - the pipeline stage payload structs
// Optional feature macro: FADD_PRE_SPECIAL_EN adds NaN/Inf flags to the
// stage payloads.
// -----------------------------------------------------------------------------
package fadd_pkg_N36;

  localparam int FRAC_WIDTH = 36;                        // significand incl. hidden bit
  localparam int EXP_WIDTH  = 8;                         // biased exponent
  localparam int W          = 1 + EXP_WIDTH + FRAC_WIDTH - 1;

  localparam int SIGN_POS = W - 1;
  localparam int EXP_MSB  = W - 2;
  localparam int EXP_LSB  = FRAC_WIDTH - 1;
  localparam int MAN_MSB  = FRAC_WIDTH - 2;
  localparam int MAN_LSB  = 0;

  typedef struct packed {
    logic                  sign;
    logic [EXP_WIDTH-1:0]  exp;
    logic [FRAC_WIDTH-1:0] sig;
  } operand_t;

  // Stage 1 payload: both operands plus the pre-computed comparison terms.
  typedef struct packed {
    operand_t              a;
    operand_t              b;          // b.sign already includes the opcode
    logic [EXP_WIDTH:0]    d;          // two's complement expA - expB
    logic                  eq_exp;
    logic                  frac_a_ge;
    logic                  sign_diff;
`ifdef FADD_PRE_SPECIAL_EN
    logic                  is_nan;
    logic                  is_inf;
    logic                  inf_sign;
`endif
  } s1_t;

  // Stage 2 payload: the swapped bundle exactly as presented downstream.
  typedef struct packed {
    logic [FRAC_WIDTH-1:0] elarge_op;
    logic [FRAC_WIDTH-1:0] esmall_op;
    logic [EXP_WIDTH-1:0]  exp_f;
    logic [EXP_WIDTH:0]    diff_abs;
    logic                  sign_diff;
    logic                  sign_res;
    logic                  near_sel;
`ifdef FADD_PRE_SPECIAL_EN
    logic                  is_nan;
    logic                  is_inf;
    logic                  inf_sign;
`endif
  } s2_t;

endpackage

// File: rtl/fadd_align_pre_n36_if.sv
// -----------------------------------------------------------------------------
// fadd_align_pre_n36_if
// Valid/ready bundle of the pre-alignment stage.
//   Input side : in_valid/in_ready, op_a, op_b, op_sub
//   Output side: out_valid/out_ready, elarge_op, esmall_op, exp_f, diff_abs,
//                sign_diff, sign_res, near_sel
//                (is_nan, is_inf, inf_sign with FADD_PRE_SPECIAL_EN)
// master: producer of operands / consumer of results
// slave : the pipeline stage itself
// -----------------------------------------------------------------------------
interface fadd_align_pre_n36_if;
  import fadd_pkg_N36::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [W-1:0]          op_a;
  logic [W-1:0]          op_b;
  logic                  op_sub;
  logic                  out_valid;
  logic                  out_ready;
  logic [FRAC_WIDTH-1:0] elarge_op;
  logic [FRAC_WIDTH-1:0] esmall_op;
  logic [EXP_WIDTH-1:0]  exp_f;
  logic [EXP_WIDTH:0]    diff_abs;
  logic                  sign_diff;
  logic                  sign_res;
  logic                  near_sel;
`ifdef FADD_PRE_SPECIAL_EN
  logic                  is_nan;
  logic                  is_inf;
  logic                  inf_sign;
`endif

  modport master (
    output in_valid, op_a, op_b, op_sub, out_ready,
    input  in_ready, out_valid, elarge_op, esmall_op, exp_f, diff_abs,
           sign_diff, sign_res, near_sel
`ifdef FADD_PRE_SPECIAL_EN
    , input is_nan, is_inf, inf_sign
`endif
  );

  modport slave (
    input  in_valid, op_a, op_b, op_sub, out_ready,
    output in_ready, out_valid, elarge_op, esmall_op, exp_f, diff_abs,
           sign_diff, sign_res, near_sel
`ifdef FADD_PRE_SPECIAL_EN
    , output is_nan, is_inf, inf_sign
`endif
  );

endinterface

// File: rtl/fadd_align_pre_n36_unpack.sv
// -----------------------------------------------------------------------------
// fadd_unpack_N36
// Combinational unpack of one packed operand.
//   word_i : packed {sign, exp, man}
//   opnd_o : {sign, exp, sig}; sig = {hidden, man}, forced to zero when exp==0
//   is_inf_o / is_nan_o (FADD_PRE_SPECIAL_EN only): all-ones exponent classes
// -----------------------------------------------------------------------------
module fadd_unpack_N36
  import fadd_pkg_N36::*;
(
  input  logic [W-1:0] word_i,
`ifdef FADD_PRE_SPECIAL_EN
  output logic         is_inf_o,
  output logic         is_nan_o,
`endif
  output operand_t     opnd_o
);

  logic [EXP_WIDTH-1:0]  exp_w;
  logic [FRAC_WIDTH-2:0] man_w;
  logic                  hidden_w;

  always_comb begin
    exp_w    = word_i[EXP_MSB:EXP_LSB];
    man_w    = word_i[MAN_MSB:MAN_LSB];
    hidden_w = |exp_w;
    opnd_o.sign = word_i[SIGN_POS];
    opnd_o.exp  = exp_w;
    // Denormals are flushed: a zero exponent zeroes the whole significand.
    opnd_o.sig  = hidden_w ? {1'b1, man_w} : '0;
  end

`ifdef FADD_PRE_SPECIAL_EN
  assign is_inf_o = (&exp_w) & ~(|man_w);
  assign is_nan_o = (&exp_w) &  (|man_w);
`endif

endmodule

// File: rtl/fadd_align_pre_n36.sv
// -----------------------------------------------------------------------------
// fadd_align_pre_n36
// Upstream stage of the 36-bit floating-point adder. Unpacks both operands,
// folds the add/sub opcode into B's sign, and orders the operands so that
// elarge_op always carries the larger magnitude. Two-stage valid/ready
// pipeline with full back-pressure and no skid buffer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : fadd_align_pre_n36_if.slave (operand input / aligned bundle output)
// Optional feature macro: FADD_PRE_SPECIAL_EN (NaN/Inf classification outputs).
// -----------------------------------------------------------------------------
module fadd_align_pre_n36
  import fadd_pkg_N36::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  fadd_align_pre_n36_if.slave  bus
);

  logic [W-1:0] raw_w [2];
  operand_t     unp_w [2];
`ifdef FADD_PRE_SPECIAL_EN
  logic         inf_w [2];
  logic         nan_w [2];
`endif

  assign raw_w[0] = bus.op_a;
  assign raw_w[1] = bus.op_b;

  for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
    fadd_unpack_N36 u_unpack (
      .word_i   (raw_w[gi]),
`ifdef FADD_PRE_SPECIAL_EN
      .is_inf_o (inf_w[gi]),
      .is_nan_o (nan_w[gi]),
`endif
      .opnd_o   (unp_w[gi])
    );
  end

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic adv1, adv2;

  operand_t           b_eff;
  logic               a_large;
  logic [EXP_WIDTH:0] diff_abs_w;
`ifdef FADD_PRE_SPECIAL_EN
  logic               nan_in;
`endif

  always_comb begin
    adv2 = ~s2_valid_q | bus.out_ready;
    adv1 = ~s1_valid_q | adv2;

    b_eff      = unp_w[1];
    b_eff.sign = unp_w[1].sign ^ bus.op_sub;

    // ---------------- Stage 1 ----------------
    s1_valid_d = adv1 ? bus.in_valid : s1_valid_q;
    s1_d       = s1_q;
`ifdef FADD_PRE_SPECIAL_EN
    nan_in = nan_w[0] | nan_w[1] |
             (inf_w[0] & inf_w[1] & (unp_w[0].sign ^ b_eff.sign));
`endif
    if (adv1 && bus.in_valid) begin
      s1_d.a         = unp_w[0];
      s1_d.b         = b_eff;
      s1_d.d         = {1'b0, unp_w[0].exp} - {1'b0, unp_w[1].exp};
      s1_d.eq_exp    = (unp_w[0].exp == unp_w[1].exp);
      s1_d.frac_a_ge = (unp_w[0].sig >= unp_w[1].sig);
      s1_d.sign_diff = unp_w[0].sign ^ b_eff.sign;
`ifdef FADD_PRE_SPECIAL_EN
      s1_d.is_nan    = nan_in;
      s1_d.is_inf    = (inf_w[0] | inf_w[1]) & ~nan_in;
      // When both are infinite and not NaN the signs agree, so A's is fine.
      s1_d.inf_sign  = inf_w[0] ? unp_w[0].sign : b_eff.sign;
`endif
    end

    // ---------------- Stage 2 ----------------
    // A wins on a strictly larger exponent, or on equal exponents with a
    // significand that is not smaller; ties favour A, which keeps
    // elarge_op >= esmall_op whenever the exponents match.
    a_large    = ~s1_q.d[EXP_WIDTH] & (~s1_q.eq_exp | s1_q.frac_a_ge);
    diff_abs_w = s1_q.d[EXP_WIDTH] ? -s1_q.d : s1_q.d;

    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    s2_d       = s2_q;
    if (adv2 && s1_valid_q) begin
      s2_d.elarge_op = a_large ? s1_q.a.sig  : s1_q.b.sig;
      s2_d.esmall_op = a_large ? s1_q.b.sig  : s1_q.a.sig;
      s2_d.exp_f     = a_large ? s1_q.a.exp  : s1_q.b.exp;
      s2_d.sign_res  = a_large ? s1_q.a.sign : s1_q.b.sign;
      s2_d.diff_abs  = diff_abs_w;
      s2_d.sign_diff = s1_q.sign_diff;
      s2_d.near_sel  = s1_q.sign_diff & (diff_abs_w <= (EXP_WIDTH+1)'(1));
`ifdef FADD_PRE_SPECIAL_EN
      s2_d.is_nan    = s1_q.is_nan;
      s2_d.is_inf    = s1_q.is_inf;
      s2_d.inf_sign  = s1_q.inf_sign;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.elarge_op = s2_q.elarge_op;
  assign bus.esmall_op = s2_q.esmall_op;
  assign bus.exp_f     = s2_q.exp_f;
  assign bus.diff_abs  = s2_q.diff_abs;
  assign bus.sign_diff = s2_q.sign_diff;
  assign bus.sign_res  = s2_q.sign_res;
  assign bus.near_sel  = s2_q.near_sel;
`ifdef FADD_PRE_SPECIAL_EN
  assign bus.is_nan    = s2_q.is_nan;
  assign bus.is_inf    = s2_q.is_inf;
  assign bus.inf_sign  = s2_q.inf_sign;
`endif

endmodule
